// File: rtl/avl_wb_multi_bridge_if.sv
// rtl/avl_wb_multi_bridge_if.sv - Avalon-MM and multi-channel Wishbone bus interfaces for the bridge
//
// avl_wb_avl_if : Avalon-MM command/response bundle.
//    master modport : CPU side (drives address/read/write/writedata/byteenable)
//    slave modport  : bridge side (drives waitrequest/readdata/readdatavalid/response)
// avl_wb_wb_if  : Wishbone classic bundle shared by N_CH peripherals.
//    master modport : bridge side (drives adr/dat/sel/we/cyc and one-hot stb)
//    slave modport  : peripheral side (drives per-channel dat_i/ack/err/irq)

interface avl_wb_avl_if #(
   parameter int AW = 8
);
   logic [AW-1:0] avl_address;
   logic          avl_read;
   logic          avl_write;
   logic [31:0]   avl_writedata;
   logic [3:0]    avl_byteenable;
   logic          avl_waitrequest;
   logic [31:0]   avl_readdata;
   logic          avl_readdatavalid;
   logic [1:0]    avl_response;

   modport master (
      output avl_address, avl_read, avl_write, avl_writedata, avl_byteenable,
      input  avl_waitrequest, avl_readdata, avl_readdatavalid, avl_response
   );

   modport slave (
      input  avl_address, avl_read, avl_write, avl_writedata, avl_byteenable,
      output avl_waitrequest, avl_readdata, avl_readdatavalid, avl_response
   );
endinterface

interface avl_wb_wb_if #(
   parameter int AW    = 8,
   parameter int CHW   = 2,
   parameter int N_CH  = 3,
   parameter int WB_DW = 8
);
   logic [AW-CHW-3:0]     wb_adr_o;
   logic [WB_DW-1:0]      wb_dat_o;
   logic [WB_DW/8-1:0]    wb_sel_o;
   logic                  wb_we_o;
   logic                  wb_cyc_o;
   logic [N_CH-1:0]       wb_stb_o;
   logic [N_CH*WB_DW-1:0] wb_dat_i;
   logic [N_CH-1:0]       wb_ack_i;
   logic [N_CH-1:0]       wb_err_i;
   logic [N_CH-1:0]       irq_i;

   modport master (
      output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
      input  wb_dat_i, wb_ack_i, wb_err_i, irq_i
   );

   modport slave (
      input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
      output wb_dat_i, wb_ack_i, wb_err_i, irq_i
   );
endinterface

// File: rtl/avl_wb_multi_bridge.sv
// rtl/avl_wb_multi_bridge.sv - Avalon-MM slave to multi-channel Wishbone classic master bridge
//
// The top CHW address bits pick one of N_CH Wishbone peripherals; each access is
// completed by the selected channel's ack (OKAY), err (SLAVEERROR), a bus timeout
// or an unmapped channel (DECODEERROR). Read data returns one cycle after completion.
//
// Ports:
//    clk_riscv  : system clock
//    rst_in     : asynchronous reset, active-low
//    avl        : Avalon-MM slave side (command in, waitrequest/readdata/response out)
//    wb         : Wishbone master side (shared adr/dat/sel/we/cyc, one-hot stb,
//                 per-channel dat_i/ack/err/irq)
//    wr_err_o   : one-cycle pulse after a write completed with error, timeout or decode error
//    irq_o      : OR of all channel interrupts

module avl_wb_multi_bridge #(
   parameter int AW      = 8,
   parameter int CHW     = 2,
   parameter int N_CH    = 3,
   parameter int WB_DW   = 8,
   parameter int TIMEOUT = 16
) (
   input  logic         clk_riscv,
   input  logic         rst_in,
   avl_wb_avl_if.slave  avl,
   avl_wb_wb_if.master  wb,
   output logic         wr_err_o,
   output logic         irq_o
);

   localparam int WAW  = AW - CHW - 2;
   localparam int SW   = WB_DW / 8;
   localparam int CNTW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNTW-1:0] CNT_LAST = CNTW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUS  = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [CHW-1:0]    ch_q, ch_d;
   logic [WAW-1:0]    adr_q, adr_d;
   logic [WB_DW-1:0]  dat_q, dat_d;
   logic [SW-1:0]     sel_q, sel_d;
   logic              we_q, we_d;
   logic [CNTW-1:0]   cnt_q, cnt_d;
   logic              rdv_q, rdv_d;
   logic [31:0]       rdata_q, rdata_d;
   logic [1:0]        resp_q, resp_d;
   logic              wr_err_q, wr_err_d;

   // Selected-channel view of the per-channel Wishbone inputs
   logic              mapped;
   logic              ack_sel;
   logic              err_sel;
   logic [WB_DW-1:0]  dat_sel;
   logic [N_CH-1:0]   stb_sel;
   logic              timeout_hit;

   // Combinational FSM outputs
   logic              done_c;
   logic [1:0]        resp_c;
   logic              waitreq_c;
   logic              cyc_c;
   logic [N_CH-1:0]   stb_c;

   // Only part of the Avalon word reaches the Wishbone side
   logic              unused_avl;
   assign unused_avl = ^{avl.avl_address, avl.avl_writedata, avl.avl_byteenable};

   assign mapped      = ({1'b0, ch_q} < (CHW + 1)'(N_CH));
   assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

   // Loop-based mux avoids indexing past the implemented channels when ch_q is unmapped
   always_comb begin
      ack_sel = 1'b0;
      err_sel = 1'b0;
      dat_sel = '0;
      stb_sel = '0;
      for (int k = 0; k < N_CH; k++) begin
         if (ch_q == CHW'(k)) begin
            ack_sel    = wb.wb_ack_i[k];
            err_sel    = wb.wb_err_i[k];
            dat_sel    = wb.wb_dat_i[k*WB_DW +: WB_DW];
            stb_sel[k] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_riscv or negedge rst_in) begin
      if (!rst_in) begin
         state_q  <= ST_IDLE;
         ch_q     <= '0;
         adr_q    <= '0;
         dat_q    <= '0;
         sel_q    <= '0;
         we_q     <= 1'b0;
         cnt_q    <= '0;
         rdv_q    <= 1'b0;
         rdata_q  <= '0;
         resp_q   <= RESP_OKAY;
         wr_err_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         ch_q     <= ch_d;
         adr_q    <= adr_d;
         dat_q    <= dat_d;
         sel_q    <= sel_d;
         we_q     <= we_d;
         cnt_q    <= cnt_d;
         rdv_q    <= rdv_d;
         rdata_q  <= rdata_d;
         resp_q   <= resp_d;
         wr_err_q <= wr_err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      ch_d      = ch_q;
      adr_d     = adr_q;
      dat_d     = dat_q;
      sel_d     = sel_q;
      we_d      = we_q;
      cnt_d     = cnt_q;
      rdv_d     = 1'b0;
      rdata_d   = '0;
      resp_d    = RESP_OKAY;
      wr_err_d  = 1'b0;
      done_c    = 1'b0;
      resp_c    = RESP_OKAY;
      waitreq_c = 1'b1;
      cyc_c     = 1'b0;
      stb_c     = '0;

      case (state_q)
         ST_IDLE: begin
            if (avl.avl_read || avl.avl_write) begin
               ch_d    = avl.avl_address[AW-1 -: CHW];
               adr_d   = avl.avl_address[AW-CHW-1:2];
               dat_d   = avl.avl_writedata[WB_DW-1:0];
               sel_d   = avl.avl_byteenable[SW-1:0];
               we_d    = avl.avl_write;
               cnt_d   = '0;
               state_d = ST_BUS;
            end
         end

         ST_BUS: begin
            if (!mapped) begin
               done_c = 1'b1;
               resp_c = RESP_DECERR;
            end else begin
               cyc_c = 1'b1;
               stb_c = stb_sel;
               if (err_sel) begin
                  done_c = 1'b1;
                  resp_c = RESP_SLVERR;
               end else if (ack_sel) begin
                  done_c = 1'b1;
                  resp_c = RESP_OKAY;
               end else if (timeout_hit) begin
                  done_c = 1'b1;
                  resp_c = RESP_DECERR;
               end
               // Saturating count of BUS cycles; frozen at zero when timeout is disabled
               if (!done_c && (TIMEOUT != 0) && (cnt_q != CNT_LAST)) begin
                  cnt_d = cnt_q + 1'b1;
               end
            end

            if (done_c) begin
               waitreq_c = 1'b0;
               state_d   = ST_IDLE;
               if (!we_q) begin
                  rdv_d   = 1'b1;
                  resp_d  = resp_c;
                  rdata_d = (resp_c == RESP_OKAY) ? 32'(dat_sel) : 32'd0;
               end else begin
                  wr_err_d = (resp_c != RESP_OKAY);
               end
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   assign avl.avl_waitrequest   = waitreq_c;
   assign avl.avl_readdata      = rdata_q;
   assign avl.avl_readdatavalid = rdv_q;
   assign avl.avl_response      = resp_q;

   assign wb.wb_adr_o = adr_q;
   assign wb.wb_dat_o = dat_q;
   assign wb.wb_sel_o = sel_q;
   assign wb.wb_we_o  = we_q;
   assign wb.wb_cyc_o = cyc_c;
   assign wb.wb_stb_o = stb_c;

   assign wr_err_o = wr_err_q;
   assign irq_o    = |wb.irq_i;

endmodule

// File: tb/tb_avl_wb_multi_bridge.sv
// tb/tb_avl_wb_multi_bridge.sv - Self-checking bench for avl_wb_multi_bridge

module tb_avl_wb_multi_bridge;

   localparam int AW      = 8;
   localparam int CHW     = 2;
   localparam int N_CH    = 3;
   localparam int WB_DW   = 8;
   localparam int TIMEOUT = 16;

   localparam int M_ACK  = 0;
   localparam int M_ERR  = 1;
   localparam int M_NONE = 2;
   localparam int M_BOTH = 3;

   logic clk_riscv = 1'b0;
   logic rst_in    = 1'b0;
   logic wr_err_o;
   logic irq_o;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk_riscv = ~clk_riscv;

   avl_wb_avl_if #(.AW(AW)) avl_bus ();
   avl_wb_wb_if  #(.AW(AW), .CHW(CHW), .N_CH(N_CH), .WB_DW(WB_DW)) wb_bus ();

   avl_wb_multi_bridge #(
      .AW(AW), .CHW(CHW), .N_CH(N_CH), .WB_DW(WB_DW), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk_riscv (clk_riscv),
      .rst_in    (rst_in),
      .avl       (avl_bus.slave),
      .wb        (wb_bus.master),
      .wr_err_o  (wr_err_o),
      .irq_o     (irq_o)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic idle_inputs();
      avl_bus.avl_read       = 1'b0;
      avl_bus.avl_write      = 1'b0;
      avl_bus.avl_address    = '0;
      avl_bus.avl_writedata  = '0;
      avl_bus.avl_byteenable = '0;
      wb_bus.wb_ack_i        = '0;
      wb_bus.wb_err_i        = '0;
      wb_bus.wb_dat_i        = '0;
      wb_bus.irq_i           = '0;
   endtask

   // One Avalon access; the selected peripheral answers per mode at BUS cycle 'delay'.
   // With noise set, every other channel acks and randomly errs on every BUS cycle.
   task automatic run_txn(input bit is_wr, input bit both_cmd, input logic [7:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be,
                          input int mode, input int delay, input logic [7:0] rdval,
                          input bit noise);
      int          chn;
      int          exp_n;
      logic [1:0]  exp_resp;
      logic [31:0] exp_data;
      logic        exp_wrerr;
      logic [2:0]  exp_stb;
      logic [2:0]  others;
      int          n;
      bit          done;

      chn = int'(addr[7:6]);

      // Reference model: which BUS cycle completes and with what response
      if (chn >= N_CH) begin
         exp_n = 0;
         exp_resp = 2'b11;
      end else if (mode == M_NONE || delay >= TIMEOUT) begin
         exp_n = TIMEOUT - 1;
         exp_resp = 2'b11;
      end else begin
         exp_n = delay;
         exp_resp = (mode == M_ACK) ? 2'b00 : 2'b10;
      end
      exp_data  = (!is_wr && exp_resp == 2'b00) ? {24'h0, rdval} : 32'h0;
      exp_wrerr = is_wr && (exp_resp != 2'b00);
      exp_stb   = (chn < N_CH) ? 3'(1 << chn) : 3'b000;
      others    = ~exp_stb;

      @(posedge clk_riscv); #1;
      avl_bus.avl_address    = addr;
      avl_bus.avl_read       = !is_wr || both_cmd;
      avl_bus.avl_write      = is_wr;
      avl_bus.avl_writedata  = wdata;
      avl_bus.avl_byteenable = be;
      wb_bus.wb_ack_i        = '0;
      wb_bus.wb_err_i        = '0;
      @(negedge clk_riscv);
      check_eq("wreq_idle", 32'(avl_bus.avl_waitrequest), 32'd1);

      n = 0;
      done = 0;
      while (!done && n < 40) begin
         @(posedge clk_riscv); #1;
         wb_bus.wb_ack_i = noise ? others : 3'b000;
         wb_bus.wb_err_i = noise ? (3'($urandom) & others) : 3'b000;
         if (chn < N_CH && n == delay) begin
            if (mode == M_ACK || mode == M_BOTH) wb_bus.wb_ack_i[chn] = 1'b1;
            if (mode == M_ERR || mode == M_BOTH) wb_bus.wb_err_i[chn] = 1'b1;
         end
         wb_bus.wb_dat_i = 24'($urandom);
         if (chn < N_CH) wb_bus.wb_dat_i[chn*8 +: 8] = rdval;
         wb_bus.irq_i = 3'($urandom);
         @(negedge clk_riscv);
         if (n == 0) begin
            check_eq("cyc", 32'(wb_bus.wb_cyc_o), 32'(chn < N_CH));
            check_eq("stb", 32'(wb_bus.wb_stb_o), 32'(exp_stb));
            check_eq("adr", 32'(wb_bus.wb_adr_o), 32'(addr[5:2]));
            check_eq("we",  32'(wb_bus.wb_we_o), 32'(is_wr));
            check_eq("dat", 32'(wb_bus.wb_dat_o), 32'(wdata[7:0]));
            check_eq("sel", 32'(wb_bus.wb_sel_o), 32'(be[0]));
            check_eq("irq", 32'(irq_o), 32'(|wb_bus.irq_i));
         end
         if (!avl_bus.avl_waitrequest) done = 1;
         else n++;
      end
      check_eq("done_cycle", 32'(n), 32'(exp_n));

      @(posedge clk_riscv); #1;
      avl_bus.avl_read  = 1'b0;
      avl_bus.avl_write = 1'b0;
      wb_bus.wb_ack_i   = '0;
      wb_bus.wb_err_i   = '0;
      @(negedge clk_riscv);
      check_eq("rdv", 32'(avl_bus.avl_readdatavalid), 32'(!is_wr));
      if (!is_wr) begin
         check_eq("rdata", avl_bus.avl_readdata, exp_data);
         check_eq("resp", 32'(avl_bus.avl_response), 32'(exp_resp));
      end
      check_eq("wr_err", 32'(wr_err_o), 32'(exp_wrerr));
      check_eq("cyc_after", 32'(wb_bus.wb_cyc_o), 32'd0);
   endtask

   initial begin
      idle_inputs();

      @(posedge clk_riscv);
      @(negedge clk_riscv);
      check_eq("rst_wreq",  32'(avl_bus.avl_waitrequest), 32'd1);
      check_eq("rst_rdv",   32'(avl_bus.avl_readdatavalid), 32'd0);
      check_eq("rst_rdata", avl_bus.avl_readdata, 32'd0);
      check_eq("rst_resp",  32'(avl_bus.avl_response), 32'd0);
      check_eq("rst_wrerr", 32'(wr_err_o), 32'd0);
      check_eq("rst_cyc",   32'(wb_bus.wb_cyc_o), 32'd0);
      check_eq("rst_stb",   32'(wb_bus.wb_stb_o), 32'd0);
      check_eq("rst_we",    32'(wb_bus.wb_we_o), 32'd0);
      check_eq("rst_adr",   32'(wb_bus.wb_adr_o), 32'd0);
      check_eq("rst_dat",   32'(wb_bus.wb_dat_o), 32'd0);
      check_eq("rst_sel",   32'(wb_bus.wb_sel_o), 32'd0);
      rst_in = 1'b1;

      // Directed cases
      run_txn(0, 0, 8'h48, 32'h0,        4'h0, M_ACK,  3, 8'h5A, 0);
      run_txn(1, 0, 8'h04, 32'h000000A5, 4'h1, M_ACK,  0, 8'h00, 0);
      run_txn(0, 0, 8'hC0, 32'h0,        4'hF, M_ACK,  0, 8'h33, 0);
      run_txn(0, 0, 8'h80, 32'h0,        4'hF, M_NONE, 0, 8'h77, 0);
      run_txn(1, 0, 8'h84, 32'h0000003C, 4'h1, M_NONE, 0, 8'h00, 0);
      run_txn(0, 0, 8'h40, 32'h0,        4'h1, M_BOTH, 1, 8'hEE, 1);
      run_txn(1, 1, 8'h10, 32'h12345678, 4'hE, M_ACK,  2, 8'h00, 0);
      run_txn(0, 0, 8'h8C, 32'h0,        4'h1, M_ACK, 15, 8'h99, 0);
      run_txn(1, 0, 8'hC4, 32'h000000FF, 4'h1, M_ACK,  0, 8'h00, 0);

      // Reset in the middle of a BUS phase
      @(posedge clk_riscv); #1;
      avl_bus.avl_address = 8'h80;
      avl_bus.avl_read    = 1'b1;
      repeat (3) @(posedge clk_riscv);
      #3;
      rst_in = 1'b0;
      #1;
      check_eq("midrst_cyc",  32'(wb_bus.wb_cyc_o), 32'd0);
      check_eq("midrst_stb",  32'(wb_bus.wb_stb_o), 32'd0);
      check_eq("midrst_wreq", 32'(avl_bus.avl_waitrequest), 32'd1);
      @(posedge clk_riscv); #1;
      avl_bus.avl_read = 1'b0;
      @(negedge clk_riscv);
      rst_in = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_riscv);
         check_eq("midrst_rdv",   32'(avl_bus.avl_readdatavalid), 32'd0);
         check_eq("midrst_wrerr", 32'(wr_err_o), 32'd0);
      end
      run_txn(0, 0, 8'h48, 32'h0, 4'h1, M_ACK, 1, 8'hC3, 0);

      // Randomized traffic
      for (int t = 0; t < 40; t++) begin
         bit          r_wr;
         bit          r_both;
         logic [7:0]  r_addr;
         logic [31:0] r_wdata;
         logic [3:0]  r_be;
         int          r_mode;
         int          r_delay;
         logic [7:0]  r_rdval;
         r_wr    = 1'($urandom);
         r_both  = 1'($urandom);
         r_addr  = 8'($urandom);
         r_wdata = $urandom;
         r_be    = 4'($urandom);
         r_mode  = $urandom_range(0, 3);
         r_delay = ($urandom_range(0, 4) == 0) ? $urandom_range(14, 20) : $urandom_range(0, 6);
         r_rdval = 8'($urandom);
         run_txn(r_wr, r_both, r_addr, r_wdata, r_be, r_mode, r_delay, r_rdval, 1'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
